// File: rtl/fu_cdb_arbiter.sv
// rtl/fu_cdb_arbiter.sv - FU result holding buffers with round-robin grant onto a registered CDB
module fu_cdb_arbiter #(
   parameter int NUM_FU    = 4,
   parameter int CDB_WIDTH = 2,
   parameter int TAG_W     = 5,
   parameter int XLEN      = 32
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                squash,
   input  logic [NUM_FU-1:0]                   fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]             fu_tag,
   input  logic [NUM_FU*XLEN-1:0]              fu_result,
   input  logic [NUM_FU-1:0]                   fu_take_branch,
   output logic [NUM_FU-1:0]                   fu_ack,
   output logic [CDB_WIDTH-1:0]                cdb_valid,
   output logic [CDB_WIDTH*TAG_W-1:0]          cdb_tag,
   output logic [CDB_WIDTH*XLEN-1:0]           cdb_value,
   output logic [CDB_WIDTH-1:0]                cdb_take_branch,
   output logic [CDB_WIDTH*$clog2(NUM_FU)-1:0] cdb_fu_idx
);

   localparam int IDX_W = $clog2(NUM_FU);

   logic [NUM_FU-1:0]    hold_valid;
   logic [NUM_FU-1:0]    hold_br;
   logic [TAG_W-1:0]     hold_tag   [NUM_FU];
   logic [XLEN-1:0]      hold_value [NUM_FU];
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     rr_next;
   logic [NUM_FU-1:0]    grant;
   logic [CDB_WIDTH-1:0] slot_vld;
   logic [IDX_W-1:0]     slot_idx [CDB_WIDTH];

   // Walk the buffers starting at rr_ptr; the k-th granted entry lands in slot k.
   always_comb begin
      int cnt;
      int j;
      grant    = '0;
      slot_vld = '0;
      rr_next  = rr_ptr;
      cnt      = 0;
      j        = 0;
      for (int s = 0; s < CDB_WIDTH; s++) slot_idx[s] = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_FU) j = j - NUM_FU;
         for (int i = 0; i < NUM_FU; i++) begin
            if (i == j && hold_valid[i] && cnt < CDB_WIDTH) begin
               grant[i] = 1'b1;
               for (int s = 0; s < CDB_WIDTH; s++) begin
                  if (s == cnt) begin
                     slot_vld[s] = 1'b1;
                     slot_idx[s] = IDX_W'(i);
                  end
               end
               rr_next = (i == NUM_FU - 1) ? '0 : IDX_W'(i + 1);
               cnt     = cnt + 1;
            end
         end
      end
   end

   // A granted buffer frees at the edge, so it can accept a new result in the same cycle.
   assign fu_ack = reset  ? '0 :
                   squash ? '1 : (~hold_valid | grant);

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid      <= '0;
         hold_br         <= '0;
         rr_ptr          <= '0;
         cdb_valid       <= '0;
         cdb_tag         <= '0;
         cdb_value       <= '0;
         cdb_take_branch <= '0;
         cdb_fu_idx      <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            hold_tag[i]   <= '0;
            hold_value[i] <= '0;
         end
      end else if (squash) begin
         hold_valid      <= '0;
         rr_ptr          <= '0;
         cdb_valid       <= '0;
         cdb_tag         <= '0;
         cdb_value       <= '0;
         cdb_take_branch <= '0;
         cdb_fu_idx      <= '0;
      end else begin
         rr_ptr <= rr_next;
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ack[i]) begin
               hold_valid[i] <= 1'b1;
               hold_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
               hold_value[i] <= fu_result[i*XLEN +: XLEN];
               hold_br[i]    <= fu_take_branch[i];
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
         for (int s = 0; s < CDB_WIDTH; s++) begin
            cdb_valid[s] <= slot_vld[s];
            if (slot_vld[s]) begin
               cdb_tag[s*TAG_W +: TAG_W]     <= hold_tag[slot_idx[s]];
               cdb_value[s*XLEN +: XLEN]     <= hold_value[slot_idx[s]];
               cdb_take_branch[s]            <= hold_br[slot_idx[s]];
               cdb_fu_idx[s*IDX_W +: IDX_W]  <= slot_idx[s];
            end else begin
               cdb_tag[s*TAG_W +: TAG_W]     <= '0;
               cdb_value[s*XLEN +: XLEN]     <= '0;
               cdb_take_branch[s]            <= 1'b0;
               cdb_fu_idx[s*IDX_W +: IDX_W]  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// tb/tb_fu_cdb_arbiter.sv - directed and randomized checks of fu_cdb_arbiter against a cycle model
module tb_fu_cdb_arbiter;
   localparam int N  = 4;
   localparam int W  = 2;
   localparam int TW = 5;
   localparam int XL = 32;
   localparam int IW = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              squash;
   logic [N-1:0]      fu_valid;
   logic [N*TW-1:0]   fu_tag;
   logic [N*XL-1:0]   fu_result;
   logic [N-1:0]      fu_take_branch;
   logic [N-1:0]      fu_ack;
   logic [W-1:0]      cdb_valid;
   logic [W*TW-1:0]   cdb_tag;
   logic [W*XL-1:0]   cdb_value;
   logic [W-1:0]      cdb_take_branch;
   logic [W*IW-1:0]   cdb_fu_idx;

   fu_cdb_arbiter #(.NUM_FU(N), .CDB_WIDTH(W), .TAG_W(TW), .XLEN(XL)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_result(fu_result),
      .fu_take_branch(fu_take_branch), .fu_ack(fu_ack),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_take_branch(cdb_take_branch), .cdb_fu_idx(cdb_fu_idx)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Model: buffer contents, pointer, and the CDB registers as plain arrays.
   logic [N-1:0]  m_hv;
   logic [N-1:0]  m_br;
   logic [TW-1:0] m_tag [N];
   logic [XL-1:0] m_val [N];
   int            m_rr;
   logic [W-1:0]  m_cv;
   logic [W-1:0]  m_cb;
   logic [TW-1:0] m_ct [W];
   logic [XL-1:0] m_cx [W];
   int            m_cf [W];
   logic [N-1:0]  m_g;
   logic [N-1:0]  m_ack;
   logic [N-1:0]  m_acc;
   int            m_slot [W];
   int            m_ns;
   logic [TW-1:0] ntag = 5'd16;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_clear();
      m_hv = '0;
      m_rr = 0;
      m_cv = '0;
      m_cb = '0;
      for (int s = 0; s < W; s++) begin
         m_ct[s] = '0;
         m_cx[s] = '0;
         m_cf[s] = 0;
      end
   endtask

   task automatic m_compute();
      int i;
      m_g  = '0;
      m_ns = 0;
      for (int s = 0; s < W; s++) m_slot[s] = 0;
      for (int k = 0; k < N; k++) begin
         i = (m_rr + k) % N;
         if (m_hv[i] && m_ns < W) begin
            m_g[i]       = 1'b1;
            m_slot[m_ns] = i;
            m_ns++;
         end
      end
      if (reset)       m_ack = '0;
      else if (squash) m_ack = '1;
      else             m_ack = ~m_hv | m_g;
      m_acc = fu_valid & m_ack;
   endtask

   task automatic m_edge();
      if (reset || squash) begin
         m_clear();
      end else begin
         for (int s = 0; s < W; s++) begin
            m_cv[s] = (s < m_ns);
            m_ct[s] = (s < m_ns) ? m_tag[m_slot[s]] : '0;
            m_cx[s] = (s < m_ns) ? m_val[m_slot[s]] : '0;
            m_cb[s] = (s < m_ns) ? m_br[m_slot[s]] : 1'b0;
            m_cf[s] = (s < m_ns) ? m_slot[s] : 0;
         end
         if (m_ns > 0) m_rr = (m_slot[m_ns-1] + 1) % N;
         for (int i = 0; i < N; i++) begin
            if (m_acc[i]) begin
               m_hv[i]  = 1'b1;
               m_tag[i] = fu_tag[i*TW +: TW];
               m_val[i] = fu_result[i*XL +: XL];
               m_br[i]  = fu_take_branch[i];
            end else if (m_g[i]) begin
               m_hv[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic compare();
      chk("fu_ack", fu_ack, m_ack);
      chk("cdb_valid", cdb_valid, m_cv);
      for (int s = 0; s < W; s++) begin
         if (m_cv[s]) begin
            chk("cdb_tag", cdb_tag[s*TW +: TW], m_ct[s]);
            chk("cdb_value", cdb_value[s*XL +: XL], m_cx[s]);
            chk("cdb_take_branch", cdb_take_branch[s], m_cb[s]);
            chk("cdb_fu_idx", cdb_fu_idx[s*IW +: IW], m_cf[s]);
         end
      end
   endtask

   task automatic step();
      #1;
      m_compute();
      compare();
      m_edge();
      @(negedge clock);
      #1;
   endtask

   task automatic set_fu(input int i, input logic v, input logic [TW-1:0] t,
                         input logic [XL-1:0] r, input logic b);
      fu_valid[i]          = v;
      fu_tag[i*TW +: TW]   = t;
      fu_result[i*XL +: XL] = r;
      fu_take_branch[i]    = b;
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) set_fu(i, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      squash         = 1'b0;
      fu_valid       = '0;
      fu_tag         = '0;
      fu_result      = '0;
      fu_take_branch = '0;
      m_clear();
      @(negedge clock);
      #1;
      chk("rst_fu_ack", fu_ack, 4'b0000);
      chk("rst_cdb_valid", cdb_valid, 2'b00);
      chk("rst_cdb_tag", cdb_tag, 10'd0);
      step();
      reset = 1'b0;

      // single result from FU1
      set_fu(1, 1'b1, 5'd7, 32'h0000_00AB, 1'b0);
      #1 chk("single_ack1", fu_ack[1], 1'b1);
      step();
      idle_all();
      step();
      chk("single_cdb_valid", cdb_valid, 2'b01);
      chk("single_tag", cdb_tag[TW-1:0], 5'd7);
      chk("single_value", cdb_value[XL-1:0], 32'hAB);
      chk("single_fu_idx", cdb_fu_idx[IW-1:0], 2'd1);
      step();
      step();

      // oversubscription: four results into two slots, FU0/FU1 reload immediately
      do_reset();
      for (int i = 0; i < N; i++) set_fu(i, 1'b1, TW'(i + 1), XL'(100 + i), 1'b0);
      #1 chk("over_ack_c0", fu_ack, 4'b1111);
      step();
      for (int i = 0; i < N; i++) set_fu(i, 1'b1, TW'(i + 5), XL'(200 + i), 1'b1);
      #1 chk("over_ack_c1", fu_ack, 4'b0011);
      step();
      set_fu(0, 1'b0, '0, '0, 1'b0);
      set_fu(1, 1'b0, '0, '0, 1'b0);
      chk("over_c2_valid", cdb_valid, 2'b11);
      chk("over_c2_tags", cdb_tag, {5'd2, 5'd1});
      chk("over_c2_idx", cdb_fu_idx, {2'd1, 2'd0});
      #1 chk("over_ack_c2", fu_ack, 4'b1100);
      step();
      idle_all();
      chk("over_c3_tags", cdb_tag, {5'd4, 5'd3});
      chk("over_c3_idx", cdb_fu_idx, {2'd3, 2'd2});
      step();
      chk("over_c4_tags", cdb_tag, {5'd6, 5'd5});
      step();
      chk("over_c5_tags", cdb_tag, {5'd8, 5'd7});
      step();

      // backpressure on FU2
      do_reset();
      set_fu(0, 1'b1, 5'd10, 32'h10, 1'b0);
      set_fu(1, 1'b1, 5'd11, 32'h11, 1'b0);
      set_fu(2, 1'b1, 5'd12, 32'h12, 1'b0);
      step();
      set_fu(0, 1'b0, '0, '0, 1'b0);
      set_fu(1, 1'b0, '0, '0, 1'b0);
      set_fu(2, 1'b1, 5'd9, 32'h99, 1'b1);
      #1 chk("bp_stall_ack2", fu_ack[2], 1'b0);
      step();
      #1 chk("bp_accept_ack2", fu_ack[2], 1'b1);
      step();
      set_fu(2, 1'b0, '0, '0, 1'b0);
      chk("bp_c3_valid", cdb_valid, 2'b01);
      chk("bp_c3_tag", cdb_tag[TW-1:0], 5'd12);
      step();
      chk("bp_c4_valid", cdb_valid, 2'b01);
      chk("bp_c4_tag", cdb_tag[TW-1:0], 5'd9);
      chk("bp_c4_idx", cdb_fu_idx[IW-1:0], 2'd2);
      chk("bp_c4_br", cdb_take_branch[0], 1'b1);
      step();
      chk("bp_once", cdb_valid, 2'b00);
      step();

      // squash with tags 5 and 6 held
      do_reset();
      set_fu(0, 1'b1, 5'd5, 32'h5, 1'b0);
      set_fu(1, 1'b1, 5'd6, 32'h6, 1'b0);
      step();
      idle_all();
      set_fu(3, 1'b1, 5'd20, 32'h20, 1'b0);
      squash = 1'b1;
      #1 chk("squash_ack", fu_ack, 4'b1111);
      step();
      squash = 1'b0;
      idle_all();
      chk("squash_c2_valid", cdb_valid, 2'b00);
      step();
      chk("squash_c3_valid", cdb_valid, 2'b00);
      step();

      // reset in the middle of operation
      set_fu(0, 1'b1, 5'd21, 32'h21, 1'b0);
      set_fu(1, 1'b1, 5'd22, 32'h22, 1'b0);
      set_fu(2, 1'b1, 5'd23, 32'h23, 1'b0);
      step();
      idle_all();
      reset = 1'b1;
      #1 chk("midrst_ack", fu_ack, 4'b0000);
      step();
      reset = 1'b0;
      chk("midrst_c2_valid", cdb_valid, 2'b00);
      set_fu(3, 1'b1, 5'd24, 32'h24, 1'b0);
      step();
      idle_all();
      chk("midrst_c3_valid", cdb_valid, 2'b00);
      step();
      chk("midrst_c4_valid", cdb_valid, 2'b01);
      chk("midrst_c4_tag", cdb_tag[TW-1:0], 5'd24);
      chk("midrst_c4_idx", cdb_fu_idx[IW-1:0], 2'd3);
      step();

      // randomized traffic with occasional squash and reset
      for (int c = 0; c < 3000; c++) begin
         squash = ($urandom_range(0, 49) == 0);
         reset  = ($urandom_range(0, 149) == 0);
         step();
         squash = 1'b0;
         reset  = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!fu_valid[i] || m_acc[i]) begin
               if ($urandom_range(0, 2) != 0) begin
                  set_fu(i, 1'b1, ntag, $urandom, 1'($urandom_range(0, 1)));
                  ntag = ntag + 5'd1;
               end else begin
                  set_fu(i, 1'b0, '0, '0, 1'b0);
               end
            end
         end
      end
      idle_all();
      for (int c = 0; c < 6; c++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
